// File: rtl/if_stage_pkg.sv
// Shared types and constants for the lapido instruction-fetch stage.
package if_stage_pkg;

  typedef enum logic [1:0] {
    IF_IDLE  = 2'd0,
    IF_REQ   = 2'd1,
    IF_DRAIN = 2'd2,
    IF_HOLD  = 2'd3
  } if_state_e;

  localparam logic [31:0] NOP_INSTR   = 32'h0;
  localparam int          PC_WIDTH_DF = 16;

endpackage

// File: rtl/if_stage_fetch_skid_buf.sv
// One-entry skid buffer holding a fetched word and its next-PC while the
// front end is stalled.
module fetch_skid_buf #(
  parameter int PC_WIDTH = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                load_i,
  input  logic                unload_i,
  input  logic                clear_i,
  input  logic [31:0]         instr_i,
  input  logic [PC_WIDTH-1:0] next_pc_i,
  output logic                full_o,
  output logic [31:0]         instr_o,
  output logic [PC_WIDTH-1:0] next_pc_o
);
  import if_stage_pkg::*;

  logic                full_q;
  logic [31:0]         instr_q;
  logic [PC_WIDTH-1:0] npc_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      full_q  <= 1'b0;
      instr_q <= NOP_INSTR;
      npc_q   <= '0;
    end else if (clear_i || unload_i) begin
      full_q <= 1'b0;
    end else if (load_i) begin
      full_q  <= 1'b1;
      instr_q <= instr_i;
      npc_q   <= next_pc_i;
    end
  end

  assign full_o    = full_q;
  assign instr_o   = instr_q;
  assign next_pc_o = npc_q;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: PC, imem req/ack handshake, redirect draining and the
// IF/ID register, with a skid entry for responses that land during a stall.
module if_stage
  import if_stage_pkg::*;
#(
  parameter int                  PC_WIDTH = PC_WIDTH_DF,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_is_jump,
  input  logic                in_branch_taken,
  input  logic [PC_WIDTH-1:0] in_jump_addr,
  input  logic [PC_WIDTH-1:0] in_branch_addr,
  input  logic                in_stall,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_data,
  output logic                out_valid,
  output logic [31:0]         out_instruction,
  output logic [PC_WIDTH-1:0] out_next_pc
);

  if_state_e           state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, addr_q, addr_d, npc_q, npc_d;
  logic                req_q, req_d, valid_q, valid_d;
  logic [31:0]         instr_q, instr_d;

  logic                ack_v, redirect;
  logic [PC_WIDTH-1:0] target, pc_inc;
  logic                skid_load, skid_unload, skid_clear, skid_full;
  logic [31:0]         skid_instr;
  logic [PC_WIDTH-1:0] skid_npc;

  fetch_skid_buf #(.PC_WIDTH(PC_WIDTH)) u_skid (
    .clk       (clk),
    .rst       (rst),
    .load_i    (skid_load),
    .unload_i  (skid_unload),
    .clear_i   (skid_clear),
    .instr_i   (imem_data),
    .next_pc_i (pc_inc),
    .full_o    (skid_full),
    .instr_o   (skid_instr),
    .next_pc_o (skid_npc)
  );

  // An ack only counts against a request we are actually presenting.
  assign ack_v    = imem_ack & req_q;
  assign redirect = in_is_jump | in_branch_taken;
  assign target   = in_is_jump ? in_jump_addr : in_branch_addr;
  assign pc_inc   = pc_q + 1'b1;

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    req_d       = req_q;
    addr_d      = addr_q;
    valid_d     = valid_q;
    instr_d     = instr_q;
    npc_d       = npc_q;
    skid_load   = 1'b0;
    skid_unload = 1'b0;
    skid_clear  = 1'b0;
    if (redirect) begin
      valid_d    = 1'b0;
      skid_clear = 1'b1;
      pc_d       = target;
      // An unanswered request must still complete; keep it on the bus.
      if (req_q && !ack_v) begin
        state_d = IF_DRAIN;
      end else begin
        state_d = IF_REQ;
        req_d   = 1'b1;
        addr_d  = target;
      end
    end else begin
      unique case (state_q)
        IF_IDLE: begin
          state_d = IF_REQ;
          req_d   = 1'b1;
          addr_d  = pc_q;
        end
        IF_REQ: begin
          if (ack_v) begin
            pc_d = pc_inc;
            if (!in_stall) begin
              valid_d = 1'b1;
              instr_d = imem_data;
              npc_d   = pc_inc;
              addr_d  = pc_inc;
            end else begin
              skid_load = 1'b1;
              req_d     = 1'b0;
              state_d   = IF_HOLD;
            end
          end else if (!in_stall) begin
            valid_d = 1'b0;
          end
        end
        IF_DRAIN: begin
          if (!in_stall) valid_d = 1'b0;
          if (ack_v) begin
            state_d = IF_REQ;
            addr_d  = pc_q;
          end
        end
        IF_HOLD: begin
          if (!in_stall && skid_full) begin
            valid_d     = 1'b1;
            instr_d     = skid_instr;
            npc_d       = skid_npc;
            skid_unload = 1'b1;
            state_d     = IF_REQ;
            req_d       = 1'b1;
            addr_d      = pc_q;
          end
        end
        default: state_d = IF_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IF_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      addr_q  <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      npc_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      instr_q <= instr_d;
      npc_q   <= npc_d;
    end
  end

  assign imem_req        = req_q;
  assign imem_addr       = addr_q;
  assign out_valid       = valid_q;
  assign out_instruction = instr_q;
  assign out_next_pc     = npc_q;

endmodule

// File: tb/tb_if_stage.sv
// Directed plus random stimulus for if_stage against a transaction-level
// model of fetch: outstanding request, discard flag and a skid queue.
module tb_if_stage;

  localparam int PCW = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic           in_is_jump, in_branch_taken, in_stall;
  logic [PCW-1:0] in_jump_addr, in_branch_addr;
  logic           imem_req, imem_ack;
  logic [PCW-1:0] imem_addr;
  logic [31:0]    imem_data;
  logic           out_valid;
  logic [31:0]    out_instruction;
  logic [PCW-1:0] out_next_pc;

  int checks = 0;
  int errors = 0;

  if_stage #(.PC_WIDTH(PCW), .RESET_PC(8'd0)) dut (
    .clk(clk), .rst(rst),
    .in_is_jump(in_is_jump), .in_branch_taken(in_branch_taken),
    .in_jump_addr(in_jump_addr), .in_branch_addr(in_branch_addr),
    .in_stall(in_stall),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_data(imem_data),
    .out_valid(out_valid), .out_instruction(out_instruction),
    .out_next_pc(out_next_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]    instr;
    logic [PCW-1:0] npc;
  } ent_t;

  // Reference model state
  logic [PCW-1:0] m_pc, m_addr, m_npc;
  logic           m_req, m_started, m_discard, m_valid;
  logic [31:0]    m_instr;
  ent_t           skq[$];

  function automatic logic [31:0] word(input logic [PCW-1:0] a);
    return {8'hA5, a, ~a, a ^ 8'h3C};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model(input logic r, input logic a, input logic s, input logic j,
                       input logic b, input logic [PCW-1:0] ja, input logic [PCW-1:0] ba,
                       input logic [31:0] d);
    logic ackv;
    ent_t e;
    if (!r) begin
      m_pc = 0; m_addr = 0; m_npc = 0; m_req = 0; m_started = 0;
      m_discard = 0; m_valid = 0; m_instr = 32'h0; skq.delete();
    end else begin
      ackv = a & m_req;
      if (j | b) begin
        m_valid = 0; skq.delete(); m_started = 1;
        m_pc = j ? ja : ba;
        if (m_req && !ackv) m_discard = 1;
        else begin m_discard = 0; m_req = 1; m_addr = m_pc; end
      end else if (!m_started) begin
        m_started = 1; m_req = 1; m_addr = m_pc;
      end else if (m_discard) begin
        if (!s) m_valid = 0;
        if (ackv) begin m_discard = 0; m_addr = m_pc; end
      end else if (skq.size() > 0) begin
        if (!s) begin
          e = skq.pop_front();
          m_valid = 1; m_instr = e.instr; m_npc = e.npc;
          m_req = 1; m_addr = m_pc;
        end
      end else if (ackv) begin
        if (!s) begin
          m_valid = 1; m_instr = d; m_npc = m_pc + 1'b1;
          m_pc = m_pc + 1'b1; m_addr = m_pc;
        end else begin
          e.instr = d; e.npc = m_pc + 1'b1;
          skq.push_back(e);
          m_pc = m_pc + 1'b1; m_req = 0;
        end
      end else if (!s) begin
        m_valid = 0;
      end
    end
  endtask

  // Drive one cycle of inputs, advance the model, clock, then compare.
  task automatic step(input logic r, input logic a, input logic s, input logic j,
                      input logic b, input logic [PCW-1:0] ja, input logic [PCW-1:0] ba);
    logic [31:0] d;
    d = word(m_addr);
    rst = r; imem_ack = a; in_stall = s; in_is_jump = j; in_branch_taken = b;
    in_jump_addr = ja; in_branch_addr = ba; imem_data = d;
    model(r, a, s, j, b, ja, ba, d);
    @(posedge clk);
    #1;
    chk("req",   {31'b0, imem_req},     {31'b0, m_req});
    chk("addr",  {24'b0, imem_addr},    {24'b0, m_addr});
    chk("valid", {31'b0, out_valid},    {31'b0, m_valid});
    chk("instr", out_instruction,       m_instr);
    chk("npc",   {24'b0, out_next_pc},  {24'b0, m_npc});
  endtask

  initial begin
    rst = 0; imem_ack = 0; in_stall = 0; in_is_jump = 0; in_branch_taken = 0;
    in_jump_addr = 0; in_branch_addr = 0; imem_data = 0;
    m_addr = 0;

    // Reset state
    step(0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 1, 8'h55, 8'h66);
    chk("rst_req",   {31'b0, imem_req},  32'd0);
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_instr", out_instruction,    32'h0);
    chk("rst_npc",   {24'b0, out_next_pc}, 32'd0);

    // Zero-wait memory after reset release
    step(1, 0, 0, 0, 0, 0, 0);
    chk("zw_addr0", {24'b0, imem_addr}, 32'd0);
    chk("zw_req0",  {31'b0, imem_req},  32'd1);
    for (int i = 1; i <= 4; i++) begin
      step(1, 1, 0, 0, 0, 0, 0);
      chk("zw_addr", {24'b0, imem_addr},   i);
      chk("zw_npc",  {24'b0, out_next_pc}, i);
      chk("zw_vld",  {31'b0, out_valid},   32'd1);
    end

    // Slow memory, jump while fetch at 5 is outstanding
    step(1, 1, 0, 1, 0, 8'h05, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 8'h40, 0);
    chk("dr_addr",  {24'b0, imem_addr}, 32'h05);
    chk("dr_valid", {31'b0, out_valid}, 32'd0);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("dr_tgt",   {24'b0, imem_addr}, 32'h40);
    chk("dr_valid2", {31'b0, out_valid}, 32'd0);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("dr_npc",   {24'b0, out_next_pc}, 32'h41);
    chk("dr_instr", out_instruction, word(8'h40));

    // Stall when word 8 arrives
    step(1, 1, 0, 1, 0, 8'h07, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    step(1, 1, 1, 0, 0, 0, 0);
    chk("st_req",   {31'b0, imem_req}, 32'd0);
    chk("st_instr", out_instruction,   word(8'h07));
    step(1, 1, 1, 0, 0, 0, 0);
    chk("st_npc",   {24'b0, out_next_pc}, 32'd8);
    step(1, 0, 0, 0, 0, 0, 0);
    chk("st_rel_instr", out_instruction,      word(8'h08));
    chk("st_rel_npc",   {24'b0, out_next_pc}, 32'd9);
    chk("st_rel_addr",  {24'b0, imem_addr},   32'd9);

    // Jump beats branch
    step(1, 1, 0, 1, 1, 8'h10, 8'h20);
    chk("jb_addr", {24'b0, imem_addr}, 32'h10);

    // PC wrap
    step(1, 1, 0, 1, 0, 8'hFF, 0);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("wr_npc",  {24'b0, out_next_pc}, 32'd0);
    chk("wr_addr", {24'b0, imem_addr},   32'd0);

    // Reset mid-request, late ack afterwards
    step(1, 1, 0, 1, 0, 8'h30, 0);
    step(1, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0);
    chk("rm_req",   {31'b0, imem_req},  32'd0);
    chk("rm_valid", {31'b0, out_valid}, 32'd0);
    chk("rm_instr", out_instruction,    32'h0);
    step(1, 1, 0, 0, 0, 0, 0);
    chk("rm_addr",   {24'b0, imem_addr}, 32'd0);
    chk("rm_valid2", {31'b0, out_valid}, 32'd0);

    // Random traffic
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 99) != 0),
           ($urandom_range(0, 1) == 1),
           ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 19) == 0),
           ($urandom_range(0, 19) == 0),
           PCW'($urandom), PCW'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the lapido pipeline: owns the PC, issues word-addressed requests to instruction memory over a req/ack handshake and fills the IF/ID register. It consumes the redirect outputs of the memory stage (jump taken, branch taken, targets) and restarts fetch at the target. Any response still in flight from the abandoned path is discarded. A one-entry skid buffer absorbs a response that arrives while the hazard unit stalls the front end.

## Interface
Parameters:
- PC_WIDTH, `PC_WIDTH from lapido_defs.v, PC and address width (word address)
- RESET_PC, 0, first fetch address after reset

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-low
- in_is_jump  in  1  memory stage jump taken
- in_branch_taken  in  1  memory stage branch taken
- in_jump_addr  in  PC_WIDTH  absolute jump target
- in_branch_addr  in  PC_WIDTH  branch target
- in_stall  in  1  hold IF/ID contents (hazard unit)
- imem_req  out  1  fetch request
- imem_addr  out  PC_WIDTH  fetch address
- imem_ack  in  1  response valid this cycle
- imem_data  in  32  instruction word, valid with imem_ack
- out_valid  out  1  IF/ID holds a real instruction
- out_instruction  out  32  fetched word
- out_next_pc  out  PC_WIDTH  fetched PC + 1 (link / branch base)

## Operation
- redirect = in_is_jump | in_branch_taken; target = in_jump_addr if in_is_jump, else in_branch_addr (jump wins if both).
- PC increments by 1 per accepted fetch, wraps modulo 2^PC_WIDTH.
- States:
  - IDLE: one cycle after reset, req=0; → REQ.
  - REQ: req=1, addr=pc.
  - DRAIN: req=1 at the abandoned address, data discarded.
  - HOLD: req=0, skid buffer full.
- REQ transitions:
  - ack & !stall: IF/ID ← {1, imem_data, pc+1}, pc ← pc+1, stay REQ.
  - ack & stall: skid ← {imem_data, pc+1}, pc ← pc+1; → HOLD.
- HOLD, stall drops: IF/ID ← skid, skid cleared; → REQ.
- Stall with no ack: IF/ID unchanged, request stays outstanding.
- Redirect (priority over stall and ack) clears out_valid and skid, pc ← target:
  - from REQ without ack: → DRAIN.
  - from REQ with ack: data discarded; → REQ at target.
  - from HOLD or IDLE: → REQ.
  - in DRAIN: pc ← newest target, stay DRAIN.
- DRAIN + ack: data discarded; → REQ.
- Handshake rules:
  - req and addr stay stable until ack is sampled high.
  - Ack while req=0 is ignored.
  - Ack may arrive in the same cycle req rises (zero-wait memory).

## Timing
- Reset values:
  - out_valid=0, out_instruction=32'h0 (NOP), out_next_pc=0.
  - imem_req=0, imem_addr=RESET_PC, pc=RESET_PC, skid empty, state IDLE.
- Redirect inputs are ignored while rst=0.
- Reset mid-request: req drops the next edge; the abandoned request needs no ack.
- First request: cycle 1 after rst deasserts.
- Zero-wait memory: one instruction per cycle.
- Latency: ack at edge N gives out_valid at edge N.
- Redirect at edge N: out_valid=0 after N.
  - If ack coincides or nothing is outstanding: req at target from cycle N+1.
  - If the old request is outstanding: req at target one cycle after its ack.
- Stall release at edge N: skid content visible after N; req re-raised in cycle N+1.

## Structure
- lapido_defs.v gains:
  - `IF_IDLE/`IF_REQ/`IF_DRAIN/`IF_HOLD (2-bit encodings).
  - `NOP_INSTR 32'h0.
- Sub-module fetch_skid_buf: one entry holding {instruction, next_pc}, with load, unload and clear controls.
- PC register, FSM and IF/ID register live in if_stage.

## Test plan
- Reset release, zero-wait memory, RESET_PC=0:
  - addr 0,1,2,3 on consecutive cycles.
  - out_next_pc 1,2,3,4 with out_valid=1 from cycle 1.
- Memory with 2-cycle ack, fetch at pc 5, in_is_jump with in_jump_addr=0x40 one cycle after req:
  - req stays at 5 until ack; that word never appears.
  - Next request at 0x40; out_next_pc 0x41.
- in_stall high when ack for pc 8 arrives:
  - req drops and IF/ID stays unchanged.
  - On stall release, out_instruction = word 8 and out_next_pc = 9; req resumes at 9.
- in_is_jump and in_branch_taken together, jump 0x10, branch 0x20: next fetch at 0x10.
- pc = 2^PC_WIDTH−1 fetched: out_next_pc = 0, next request address 0.
- rst low while a request is outstanding:
  - Next edge: req=0, out_valid=0, out_instruction=0.
  - After release: fetch restarts at RESET_PC and the late ack is ignored.
